// File: rtl/vga_timing_pkg.sv
// Shared timing types, reset defaults and legality helpers for the VGA timing generator.
package vga_timing_pkg;
    localparam int VGA_TW    = 16;
    localparam int VGA_TOT_W = VGA_TW + 2;

    localparam int   VGA_DEF_H_VISIBLE  = 640;
    localparam int   VGA_DEF_H_FRONT    = 16;
    localparam int   VGA_DEF_H_SYNC     = 96;
    localparam int   VGA_DEF_H_BACK     = 48;
    localparam int   VGA_DEF_V_VISIBLE  = 480;
    localparam int   VGA_DEF_V_FRONT    = 10;
    localparam int   VGA_DEF_V_SYNC     = 2;
    localparam int   VGA_DEF_V_BACK     = 33;
    localparam logic VGA_DEF_H_POLARITY = 1'b0;
    localparam logic VGA_DEF_V_POLARITY = 1'b0;

    typedef struct packed {
        logic [VGA_TW-1:0] visible;
        logic [VGA_TW-1:0] front;
        logic [VGA_TW-1:0] sync;
        logic [VGA_TW-1:0] back;
        logic              polarity;
    } vga_axis_timing_t;

    // Wide enough that four maximal fields can never wrap and look legal.
    function automatic logic [VGA_TOT_W-1:0] axis_total(input vga_axis_timing_t t);
        return VGA_TOT_W'(t.visible) + VGA_TOT_W'(t.front)
             + VGA_TOT_W'(t.sync) + VGA_TOT_W'(t.back);
    endfunction

    function automatic logic axis_legal(input vga_axis_timing_t t, input int position_width);
        return (t.visible != '0) && (t.sync != '0)
            && (int'(axis_total(t)) <= ((1 << position_width) - 1));
    endfunction
endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: position counter with terminal-count wrap plus sync/visible decode.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int POSITION_WIDTH = 12
) (
    input  logic                      pixel_clock,
    input  logic                      reset_n,
    input  logic                      advance,
    input  vga_axis_timing_t          timing,
    output logic [POSITION_WIDTH-1:0] position,
    output logic                      wrap,
    output logic                      sync,
    output logic                      visible
);
    logic [POSITION_WIDTH-1:0] position_q, position_d;
    logic [VGA_TOT_W-1:0]      pos_ext, last_pos, sync_start, sync_end;

    always_comb begin
        pos_ext    = VGA_TOT_W'(position_q);
        last_pos   = axis_total(timing) - 1'b1;
        sync_start = VGA_TOT_W'(timing.visible) + VGA_TOT_W'(timing.front);
        sync_end   = sync_start + VGA_TOT_W'(timing.sync);
        // >= rather than == so an out-of-range position after a timing change recovers.
        wrap       = (pos_ext >= last_pos);
        visible    = (pos_ext < VGA_TOT_W'(timing.visible));
        sync       = ((pos_ext >= sync_start) && (pos_ext < sync_end)) ?
                     timing.polarity : ~timing.polarity;
        position_d = position_q;
        if (advance)
            position_d = wrap ? '0 : position_q + 1'b1;
    end

    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n)
            position_q <= '0;
        else
            position_q <= position_d;
    end

    assign position = position_q;
endmodule

// File: rtl/vga_timing_gen.sv
// Reprogrammable VGA timing generator: shadowed timing applied at frame end, aligned delayed outputs.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   POSITION_WIDTH = 12,
    parameter int   DEF_H_VISIBLE  = VGA_DEF_H_VISIBLE,
    parameter int   DEF_H_FRONT    = VGA_DEF_H_FRONT,
    parameter int   DEF_H_SYNC     = VGA_DEF_H_SYNC,
    parameter int   DEF_H_BACK     = VGA_DEF_H_BACK,
    parameter int   DEF_V_VISIBLE  = VGA_DEF_V_VISIBLE,
    parameter int   DEF_V_FRONT    = VGA_DEF_V_FRONT,
    parameter int   DEF_V_SYNC     = VGA_DEF_V_SYNC,
    parameter int   DEF_V_BACK     = VGA_DEF_V_BACK,
    parameter logic DEF_H_POLARITY = VGA_DEF_H_POLARITY,
    parameter logic DEF_V_POLARITY = VGA_DEF_V_POLARITY,
    parameter int   OUTPUT_DELAY   = 0
) (
    input  logic                      pixel_clock,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic                      cfg_write,
    input  logic [POSITION_WIDTH-1:0] cfg_h_visible,
    input  logic [POSITION_WIDTH-1:0] cfg_h_front,
    input  logic [POSITION_WIDTH-1:0] cfg_h_sync,
    input  logic [POSITION_WIDTH-1:0] cfg_h_back,
    input  logic [POSITION_WIDTH-1:0] cfg_v_visible,
    input  logic [POSITION_WIDTH-1:0] cfg_v_front,
    input  logic [POSITION_WIDTH-1:0] cfg_v_sync,
    input  logic [POSITION_WIDTH-1:0] cfg_v_back,
    input  logic                      cfg_h_polarity,
    input  logic                      cfg_v_polarity,
    output logic                      cfg_pending,
    output logic                      cfg_error,
    output logic [POSITION_WIDTH-1:0] h_position,
    output logic [POSITION_WIDTH-1:0] v_position,
    output logic                      visible_area,
    output logic                      vga_horizontal_sync,
    output logic                      vga_vertical_sync,
    output logic                      line_start,
    output logic                      frame_start
);
    localparam vga_axis_timing_t DEF_H = '{visible: VGA_TW'(DEF_H_VISIBLE), front: VGA_TW'(DEF_H_FRONT),
                                           sync: VGA_TW'(DEF_H_SYNC), back: VGA_TW'(DEF_H_BACK),
                                           polarity: DEF_H_POLARITY};
    localparam vga_axis_timing_t DEF_V = '{visible: VGA_TW'(DEF_V_VISIBLE), front: VGA_TW'(DEF_V_FRONT),
                                           sync: VGA_TW'(DEF_V_SYNC), back: VGA_TW'(DEF_V_BACK),
                                           polarity: DEF_V_POLARITY};
    localparam int OUT_W = 2 * POSITION_WIDTH + 5;
    localparam logic [OUT_W-1:0] OUT_RST = {{(2 * POSITION_WIDTH){1'b0}}, 1'b0,
                                            ~DEF_H_POLARITY, ~DEF_V_POLARITY, 2'b00};

    vga_axis_timing_t h_active_q, h_active_d, v_active_q, v_active_d;
    vga_axis_timing_t h_shadow_q, h_shadow_d, v_shadow_q, v_shadow_d;
    vga_axis_timing_t cfg_h, cfg_v;
    logic             cfg_pending_q, cfg_pending_d, cfg_error_q, cfg_error_d;
    logic             cfg_legal, frame_end;
    logic             h_wrap, v_wrap, h_sync, v_sync, h_vis, v_vis;
    logic [POSITION_WIDTH-1:0] h_pos, v_pos;
    logic [OUT_W-1:0] out_d;
    logic [OUT_W-1:0] out_q [OUTPUT_DELAY+1];

    always_comb begin
        cfg_h = '{visible: VGA_TW'(cfg_h_visible), front: VGA_TW'(cfg_h_front),
                  sync: VGA_TW'(cfg_h_sync), back: VGA_TW'(cfg_h_back), polarity: cfg_h_polarity};
        cfg_v = '{visible: VGA_TW'(cfg_v_visible), front: VGA_TW'(cfg_v_front),
                  sync: VGA_TW'(cfg_v_sync), back: VGA_TW'(cfg_v_back), polarity: cfg_v_polarity};
        cfg_legal     = axis_legal(cfg_h, POSITION_WIDTH) && axis_legal(cfg_v, POSITION_WIDTH);
        frame_end     = enable && h_wrap && v_wrap;
        h_active_d    = h_active_q;
        v_active_d    = v_active_q;
        h_shadow_d    = h_shadow_q;
        v_shadow_d    = v_shadow_q;
        cfg_pending_d = cfg_pending_q;
        cfg_error_d   = cfg_write && !cfg_legal;
        if (frame_end && cfg_pending_q) begin
            h_active_d    = h_shadow_q;
            v_active_d    = v_shadow_q;
            cfg_pending_d = 1'b0;
        end
        // Evaluated after the apply so a write on the wrap cycle stays pending for the next frame.
        if (cfg_write && cfg_legal) begin
            h_shadow_d    = cfg_h;
            v_shadow_d    = cfg_v;
            cfg_pending_d = 1'b1;
        end
    end

    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) begin
            h_active_q    <= DEF_H;
            v_active_q    <= DEF_V;
            h_shadow_q    <= DEF_H;
            v_shadow_q    <= DEF_V;
            cfg_pending_q <= 1'b0;
            cfg_error_q   <= 1'b0;
        end else begin
            h_active_q    <= h_active_d;
            v_active_q    <= v_active_d;
            h_shadow_q    <= h_shadow_d;
            v_shadow_q    <= v_shadow_d;
            cfg_pending_q <= cfg_pending_d;
            cfg_error_q   <= cfg_error_d;
        end
    end

    vga_axis_counter #(.POSITION_WIDTH(POSITION_WIDTH)) u_h_counter (
        .pixel_clock(pixel_clock), .reset_n(reset_n), .advance(enable), .timing(h_active_q),
        .position(h_pos), .wrap(h_wrap), .sync(h_sync), .visible(h_vis)
    );

    vga_axis_counter #(.POSITION_WIDTH(POSITION_WIDTH)) u_v_counter (
        .pixel_clock(pixel_clock), .reset_n(reset_n), .advance(enable && h_wrap), .timing(v_active_q),
        .position(v_pos), .wrap(v_wrap), .sync(v_sync), .visible(v_vis)
    );

    assign out_d = {h_pos, v_pos, h_vis && v_vis, h_sync, v_sync,
                    h_pos == '0, (h_pos == '0) && (v_pos == '0)};

    // Stage 0 registers the decode with the positions; further stages are pure delay.
    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i <= OUTPUT_DELAY; i++)
                out_q[i] <= OUT_RST;
        end else if (enable) begin
            out_q[0] <= out_d;
            for (int i = 1; i <= OUTPUT_DELAY; i++)
                out_q[i] <= out_q[i-1];
        end
    end

    assign {h_position, v_position, visible_area, vga_horizontal_sync, vga_vertical_sync,
            line_start, frame_start} = out_q[OUTPUT_DELAY];
    assign cfg_pending = cfg_pending_q;
    assign cfg_error   = cfg_error_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 800x525 instance for line checks, small 16x8 instances for frame/config/delay.
module tb_vga_timing_gen;
    localparam int PW = 12;
    localparam int OW = 2 * PW + 5;
    localparam logic [OW-1:0] RST_V = {{(2 * PW){1'b0}}, 5'b01100};

    logic clk = 1'b0;
    logic rst_n, en, cfg_wr, cfg_hp, cfg_vp;
    logic [PW-1:0] cfg_hv, cfg_hf, cfg_hs, cfg_hb, cfg_vv, cfg_vf, cfg_vs, cfg_vb;
    wire  [OW-1:0] o_def, o0, o3;
    wire pend_def, errf_def, pend0, err0, pend3, err3;

    wire [PW-1:0] h0 = o0[28:17];
    wire [PW-1:0] v0 = o0[16:5];
    wire [PW-1:0] hd = o_def[28:17];
    wire hs0 = o0[3], vs0 = o0[2], ls0 = o0[1], fs0 = o0[0];

    int n_checks = 0, n_fail = 0;
    int k = 0, err_small = 0, err_def = 0, err_dly = 0, def_hs_low = 0, def_vis = 0, def_ls = 0;
    bit model_on = 0;
    logic [OW-1:0] hist [4];

    always #5 clk = ~clk;

    vga_timing_gen u_def (
        .pixel_clock(clk), .reset_n(rst_n), .enable(en), .cfg_write(1'b0),
        .cfg_h_visible(cfg_hv), .cfg_h_front(cfg_hf), .cfg_h_sync(cfg_hs), .cfg_h_back(cfg_hb),
        .cfg_v_visible(cfg_vv), .cfg_v_front(cfg_vf), .cfg_v_sync(cfg_vs), .cfg_v_back(cfg_vb),
        .cfg_h_polarity(cfg_hp), .cfg_v_polarity(cfg_vp), .cfg_pending(pend_def), .cfg_error(errf_def),
        .h_position(o_def[28:17]), .v_position(o_def[16:5]), .visible_area(o_def[4]),
        .vga_horizontal_sync(o_def[3]), .vga_vertical_sync(o_def[2]),
        .line_start(o_def[1]), .frame_start(o_def[0]));

    vga_timing_gen #(.DEF_H_VISIBLE(8), .DEF_H_FRONT(2), .DEF_H_SYNC(3), .DEF_H_BACK(3),
                     .DEF_V_VISIBLE(4), .DEF_V_FRONT(1), .DEF_V_SYNC(2), .DEF_V_BACK(1),
                     .OUTPUT_DELAY(0)) u_small0 (
        .pixel_clock(clk), .reset_n(rst_n), .enable(en), .cfg_write(cfg_wr),
        .cfg_h_visible(cfg_hv), .cfg_h_front(cfg_hf), .cfg_h_sync(cfg_hs), .cfg_h_back(cfg_hb),
        .cfg_v_visible(cfg_vv), .cfg_v_front(cfg_vf), .cfg_v_sync(cfg_vs), .cfg_v_back(cfg_vb),
        .cfg_h_polarity(cfg_hp), .cfg_v_polarity(cfg_vp), .cfg_pending(pend0), .cfg_error(err0),
        .h_position(o0[28:17]), .v_position(o0[16:5]), .visible_area(o0[4]),
        .vga_horizontal_sync(o0[3]), .vga_vertical_sync(o0[2]),
        .line_start(o0[1]), .frame_start(o0[0]));

    vga_timing_gen #(.DEF_H_VISIBLE(8), .DEF_H_FRONT(2), .DEF_H_SYNC(3), .DEF_H_BACK(3),
                     .DEF_V_VISIBLE(4), .DEF_V_FRONT(1), .DEF_V_SYNC(2), .DEF_V_BACK(1),
                     .OUTPUT_DELAY(3)) u_small3 (
        .pixel_clock(clk), .reset_n(rst_n), .enable(en), .cfg_write(cfg_wr),
        .cfg_h_visible(cfg_hv), .cfg_h_front(cfg_hf), .cfg_h_sync(cfg_hs), .cfg_h_back(cfg_hb),
        .cfg_v_visible(cfg_vv), .cfg_v_front(cfg_vf), .cfg_v_sync(cfg_vs), .cfg_v_back(cfg_vb),
        .cfg_h_polarity(cfg_hp), .cfg_v_polarity(cfg_vp), .cfg_pending(pend3), .cfg_error(err3),
        .h_position(o3[28:17]), .v_position(o3[16:5]), .visible_area(o3[4]),
        .vga_horizontal_sync(o3[3]), .vga_vertical_sync(o3[2]),
        .line_start(o3[1]), .frame_start(o3[0]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // One clock; sample at the falling edge, track delayed-instance alignment and the reset-origin model.
    task automatic step();
        int h, v;
        logic [OW-1:0] e;
        @(negedge clk);
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) hist[i] = RST_V;
        end else if (en) begin
            for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = o0;
        end
        if (o3 !== hist[3]) err_dly++;
        if (model_on && rst_n && en) begin
            k++;
            h = (k - 1) % 16;
            v = ((k - 1) / 16) % 8;
            e = {PW'(h), PW'(v), (h < 8) && (v < 4), !(h >= 10 && h < 13), !(v >= 5 && v < 7),
                 h == 0, (h == 0) && (v == 0)};
            if (o0 !== e) err_small++;
            h = (k - 1) % 800;
            v = (k - 1) / 800;
            e = {PW'(h), PW'(v), (h < 640) && (v < 480), !(h >= 656 && h < 752), !(v >= 490 && v < 492),
                 h == 0, (h == 0) && (v == 0)};
            if (o_def !== e) err_def++;
            if (k <= 800 && !o_def[3]) def_hs_low++;
            if (k <= 800 && o_def[4]) def_vis++;
            if (o_def[1]) def_ls++;
        end
    endtask

    task automatic wait_fs(input string tag, output int n, output int nls, output int nhs, output int nvs);
        n = 0; nls = 0; nhs = 0; nvs = 0;
        do begin
            step();
            n++;
            if (ls0) nls++;
            if (hs0) nhs++;
            if (vs0) nvs++;
        end while (!fs0 && n < 3000);
        if (!fs0) check({tag, "_timeout"}, 32'(fs0), 1);
    endtask

    task automatic seek(input string tag, input int h, input int v);
        int n = 0;
        do begin
            step();
            n++;
        end while (!(h0 == PW'(h) && v0 == PW'(v)) && n < 3000);
        if (!(h0 == PW'(h) && v0 == PW'(v))) check({tag, "_timeout"}, 32'(h0), h);
    endtask

    task automatic cfg(input int hv, hf, hs, hb, vv, vf, vs, vb, input logic hp, vp);
        cfg_hv = PW'(hv); cfg_hf = PW'(hf); cfg_hs = PW'(hs); cfg_hb = PW'(hb);
        cfg_vv = PW'(vv); cfg_vf = PW'(vf); cfg_vs = PW'(vs); cfg_vb = PW'(vb);
        cfg_hp = hp; cfg_vp = vp; cfg_wr = 1'b1;
        step();
        cfg_wr = 1'b0;
    endtask

    initial begin
        int n, nls, nhs, nvs, frz;
        logic [OW-1:0] snap_d, snap_0;
        rst_n = 1'b0; en = 1'b0; cfg_wr = 1'b0; cfg_hp = 1'b0; cfg_vp = 1'b0;
        cfg_hv = '0; cfg_hf = '0; cfg_hs = '0; cfg_hb = '0;
        cfg_vv = '0; cfg_vf = '0; cfg_vs = '0; cfg_vb = '0;
        for (int i = 0; i < 4; i++) hist[i] = RST_V;
        repeat (3) step();
        check("rst_out_def", o_def, RST_V);
        check("rst_out_small", o0, RST_V);
        check("rst_out_dly", o3, RST_V);
        check("rst_pend_err", {pend0, err0, pend3, err3, pend_def, errf_def}, 0);

        // Defaults from reset release
        rst_n = 1'b1; en = 1'b1; model_on = 1;
        repeat (1700) step();
        model_on = 0;
        check("small_model_errs", err_small, 0);
        check("def_model_errs", err_def, 0);
        check("def_hsync_low_cycles", def_hs_low, 96);
        check("def_visible_cycles", def_vis, 640);
        check("def_line_starts", def_ls, 3);
        wait_fs("fs_sync", n, nls, nhs, nvs);
        wait_fs("fs_def", n, nls, nhs, nvs);
        check("def_frame_period", n, 128);
        check("def_frame_lines", nls, 8);
        check("def_hsync_high", nhs, 104);
        check("def_vsync_high", nvs, 96);

        // Mid-frame legal write, applied at frame end
        repeat (40) step();
        cfg(6, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1);
        check("pend_after_write", pend0, 1);
        check("err_after_legal", err0, 0);
        seek("seek_a", 14, 7);
        check("pend_before_wrap", pend0, 1);
        wait_fs("fs_apply", n, nls, nhs, nvs);
        check("pend_cleared", pend0, 0);
        check("new_origin_flags", o0[4:0], 5'b10011);
        wait_fs("fs_new", n, nls, nhs, nvs);
        check("new_frame_period", n, 60);
        check("new_frame_lines", nls, 6);
        check("new_hsync_active", nhs, 12);
        check("new_vsync_active", nvs, 10);

        // Rejected writes, then last-write-wins
        cfg(0, 1, 2, 1, 3, 1, 1, 1, 1'b0, 1'b0);
        check("err_vis0", err0, 1);
        check("pend_vis0", pend0, 0);
        step();
        check("err_one_cycle", err0, 0);
        cfg(4000, 50, 40, 6, 3, 1, 1, 1, 1'b0, 1'b0);
        check("err_total_4096", {err0, pend0}, 2'b10);
        cfg(6, 1, 2, 1, 3, 1, 0, 1, 1'b0, 1'b0);
        check("err_vsync0", {err0, pend0}, 2'b10);
        cfg(4000, 50, 40, 5, 3, 1, 1, 1, 1'b0, 1'b0);
        check("legal_total_4095", {err0, pend0}, 2'b01);
        cfg(8, 2, 3, 3, 4, 1, 2, 1, 1'b0, 1'b0);
        wait_fs("fs_apply2", n, nls, nhs, nvs);
        wait_fs("fs_last", n, nls, nhs, nvs);
        check("last_write_period", n, 128);
        check("last_write_hsync", nhs, 104);

        // Write landing on the wrap edge waits one more frame
        seek("seek_b", 14, 7);
        cfg(6, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1);
        check("wrap_write_pend", pend0, 1);
        wait_fs("fs_wrap", n, nls, nhs, nvs);
        check("wrap_write_fs_next", n, 1);
        check("wrap_write_still_pend", pend0, 1);
        wait_fs("fs_old", n, nls, nhs, nvs);
        check("wrap_write_old_period", n, 128);
        wait_fs("fs_z", n, nls, nhs, nvs);
        check("wrap_write_new_period", n, 60);

        // Enable hold at h = 300 on the default instance
        n = 0;
        do begin step(); n++; end while (hd != PW'(300) && n < 1000);
        check("reach_h300", hd, 300);
        snap_d = o_def; snap_0 = o0; frz = 0;
        en = 1'b0;
        repeat (100) begin
            step();
            if (o_def !== snap_d || o0 !== snap_0) frz++;
        end
        check("freeze_errs", frz, 0);
        en = 1'b1;
        step();
        check("resume_301", hd, 301);
        step();
        check("resume_302", hd, 302);

        // Async reset mid-frame with a write pending
        cfg(5, 1, 1, 1, 2, 1, 1, 1, 1'b0, 1'b0);
        check("pend_before_reset", pend0, 1);
        seek("seek_c", 2, 3);
        rst_n = 1'b0;
        #1;
        check("async_rst_small", o0, RST_V);
        check("async_rst_dly", o3, RST_V);
        check("async_rst_def", o_def, RST_V);
        check("async_rst_pend", pend0, 0);
        repeat (2) step();
        rst_n = 1'b1;
        step();
        check("restart_small", o0, {PW'(0), PW'(0), 5'b11111});
        check("restart_def", o_def, {PW'(0), PW'(0), 5'b11111});
        wait_fs("fs_restart", n, nls, nhs, nvs);
        check("restart_period", n, 128);
        check("restart_pend", pend0, 0);
        check("delay_align_errs", err_dly, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
